// File: rtl/gbf_pingpong_loader.sv
// Ping-pong write-side feeder for two global-buffer RAMs.
// Packs narrow input beats into RAM lines and alternates buffers.
module gbf_pingpong_loader #(
  parameter int IN_BITWIDTH   = 64,
  parameter int DATA_BITWIDTH = 256,
  parameter int ADDR_BITWIDTH = 5,
  parameter int DEPTH         = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [IN_BITWIDTH-1:0]   in_data,
  output logic                     in_ready,
  input  logic [1:0]               buf_release,
  output logic [1:0]               ena,
  output logic                     wea,
  output logic [ADDR_BITWIDTH-1:0] addra,
  output logic [DATA_BITWIDTH-1:0] dia,
  output logic [1:0]               buf_full,
  output logic                     fill_done,
  output logic                     fill_buf_id
);

  localparam int BEATS = DATA_BITWIDTH / IN_BITWIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = DATA_BITWIDTH - IN_BITWIDTH;

  logic                     tgt;
  logic [BW-1:0]            beat_cnt;
  logic [ADDR_BITWIDTH-1:0] line_cnt;
  logic [PW-1:0]            pack;
  logic                     pend_full;
  logic                     pend_id;
  logic [1:0]               nxt_full;
  logic                     accept;
  logic                     last_beat;
  logic                     last_line;
  logic                     line_done;

  assign in_ready  = ~reset & ~buf_full[tgt];
  assign accept    = in_valid & in_ready;
  assign last_beat = beat_cnt == BW'(BEATS-1);
  assign last_line = line_cnt == ADDR_BITWIDTH'(DEPTH-1);
  assign line_done = accept & last_beat;

  // Collect the leading beats of a line, LSB-first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack <= '0;
    end else if (accept && !last_beat) begin
      for (int k = 0; k < BEATS-1; k++) begin
        if (beat_cnt == BW'(k))
          pack[k*IN_BITWIDTH +: IN_BITWIDTH] <= in_data;
      end
    end
  end

  // Beat, line and target-buffer counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      line_cnt <= '0;
      tgt      <= 1'b0;
    end else if (accept) begin
      if (!last_beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end else begin
        beat_cnt <= '0;
        if (last_line) begin
          line_cnt <= '0;
          tgt      <= ~tgt;
        end else begin
          line_cnt <= line_cnt + 1'b1;
        end
      end
    end
  end

  // One-cycle port-A write strobe; address and data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ena   <= '0;
      wea   <= 1'b0;
      addra <= '0;
      dia   <= '0;
    end else begin
      ena <= '0;
      wea <= 1'b0;
      if (line_done) begin
        ena   <= tgt ? 2'b10 : 2'b01;
        wea   <= 1'b1;
        addra <= line_cnt;
        dia   <= {in_data, pack};
      end
    end
  end

  // Release sees the old flag, so a same-cycle set always wins.
  always_comb begin
    nxt_full = buf_full & ~buf_release;
    if (pend_full)
      nxt_full[pend_id] = 1'b1;
  end

  // Full flags lag the last strobe by a cycle so the RAM write lands first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full    <= '0;
      pend_full   <= 1'b0;
      pend_id     <= 1'b0;
      fill_done   <= 1'b0;
      fill_buf_id <= 1'b0;
    end else begin
      buf_full  <= nxt_full;
      fill_done <= pend_full;
      if (pend_full)
        fill_buf_id <= pend_id;
      pend_full <= line_done & last_line;
      if (line_done && last_line)
        pend_id <= tgt;
    end
  end

endmodule

// File: tb/tb_gbf_pingpong_loader.sv
// Scoreboard bench for gbf_pingpong_loader.
// Reference: line j lands in buffer (j/DEPTH)%2 at address j%DEPTH.
module tb_gbf_pingpong_loader;

  localparam int IW    = 64;
  localparam int DW    = 256;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int BEATS = DW / IW;

  typedef struct {
    logic           b;
    int             a;
    logic [DW-1:0]  d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_ready;
  logic [1:0]    buf_release = '0;
  logic [1:0]    ena;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dia;
  logic [1:0]    buf_full;
  logic          fill_done;
  logic          fill_buf_id;

  int tests = 0;
  int fails = 0;

  wr_t wq[$];
  bit  fq[$];

  logic [1:0]                m_full = '0;
  bit                        m_pend = 0;
  bit                        m_pend_id = 0;
  int                        m_lines = 0;
  int                        m_beat = 0;
  bit                        m_ready = 0;
  logic [BEATS-1:0][IW-1:0]  lb;

  gbf_pingpong_loader #(
    .IN_BITWIDTH(IW),
    .DATA_BITWIDTH(DW),
    .ADDR_BITWIDTH(AW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .buf_release(buf_release),
    .ena(ena),
    .wea(wea),
    .addra(addra),
    .dia(dia),
    .buf_full(buf_full),
    .fill_done(fill_done),
    .fill_buf_id(fill_buf_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] a,
                     input logic [DW-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic flag_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Reference model: advance one clock edge using the driven inputs.
  task automatic model_step(input logic v, input logic [IW-1:0] d,
                            input logic [1:0] r);
    logic [1:0] nf;
    wr_t        w;
    nf = m_full & ~r;
    if (m_pend) begin
      nf[m_pend_id] = 1'b1;
      fq.push_back(m_pend_id);
    end
    m_pend = 0;
    if (v && m_ready) begin
      lb[m_beat] = d;
      m_beat++;
      if (m_beat == BEATS) begin
        w.b = 1'((m_lines / DEPTH) % 2);
        w.a = m_lines % DEPTH;
        w.d = lb;
        wq.push_back(w);
        if (w.a == DEPTH-1) begin
          m_pend = 1;
          m_pend_id = w.b;
        end
        m_lines++;
        m_beat = 0;
      end
    end
    m_full = nf;
    m_ready = !m_full[(m_lines / DEPTH) % 2];
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] d,
                       input logic [1:0] r);
    @(negedge clk);
    chk("in_ready", DW'(in_ready), DW'(m_ready));
    in_valid = v;
    in_data = d;
    buf_release = r;
    @(posedge clk);
    model_step(v, d, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    buf_release = '0;
    #1;
    chk("rst_ena", DW'(ena), '0);
    chk("rst_wea", DW'(wea), '0);
    chk("rst_addra", DW'(addra), '0);
    chk("rst_dia", dia, '0);
    chk("rst_buf_full", DW'(buf_full), '0);
    chk("rst_fill_done", DW'(fill_done), '0);
    chk("rst_fill_buf_id", DW'(fill_buf_id), '0);
    chk("rst_in_ready", DW'(in_ready), '0);
    m_full = '0;
    m_pend = 0;
    m_pend_id = 0;
    m_lines = 0;
    m_beat = 0;
    m_ready = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_ready = 1;
    chk("in_ready_after_rst", DW'(in_ready), DW'(m_ready));
  endtask

  // Monitor: pop and compare whenever the DUT presents a write or fill.
  initial begin
    wr_t w;
    bit  id;
    forever begin
      @(posedge clk);
      #1;
      chk("buf_full", DW'(buf_full), DW'(m_full));
      if (wea || ena != 2'b00) begin
        if (wq.size() == 0) begin
          flag_fail("unexpected_write");
        end else begin
          w = wq.pop_front();
          chk("ena", DW'(ena), DW'(w.b ? 2'b10 : 2'b01));
          chk("wea", DW'(wea), DW'(1'b1));
          chk("addra", DW'(addra), DW'(w.a));
          chk("dia", dia, w.d);
        end
      end else if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("missing_write_ena", DW'(ena), DW'(w.b ? 2'b10 : 2'b01));
      end
      if (fill_done) begin
        if (fq.size() == 0) begin
          flag_fail("unexpected_fill_done");
        end else begin
          id = fq.pop_front();
          chk("fill_buf_id", DW'(fill_buf_id), DW'(id));
        end
      end else if (fq.size() != 0) begin
        id = fq.pop_front();
        chk("missing_fill_done", DW'(fill_done), DW'(1'b1));
      end
    end
  end

  initial begin
    #1;
    chk("init_ena", DW'(ena), '0);
    chk("init_in_ready", DW'(in_ready), '0);
    do_reset();

    // Gapless fill of both buffers; release both during buffer 0's full set.
    for (int i = 0; i < 256; i++)
      drive(1'b1, IW'(i), (i == 128) ? 2'b11 : 2'b00);
    for (int i = 0; i < 3; i++)
      drive(1'b1, IW'(1000 + i), 2'b00);

    // Free buffer 0, then write one line into it.
    drive(1'b0, '0, 2'b01);
    for (int i = 0; i < BEATS; i++)
      drive(1'b1, IW'(300 + i), 2'b00);

    // Free buffer 1 and stream with in_valid toggling.
    drive(1'b0, '0, 2'b10);
    for (int i = 0; i < 32; i++)
      drive(1'(i % 2 == 0), IW'(400 + i / 2), 2'b00);

    // Reset mid-line: partial beats must be discarded.
    do_reset();
    for (int i = 0; i < 6; i++)
      drive(1'b1, IW'(i), 2'b00);
    do_reset();
    for (int i = 0; i < 8; i++)
      drive(1'b1, IW'(500 + i), 2'b00);

    // Randomized traffic and releases.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] r;
      r[0] = ($urandom % 16) == 0;
      r[1] = ($urandom % 16) == 0;
      drive(1'(($urandom % 4) != 0), {$urandom, $urandom}, r);
    end

    for (int i = 0; i < 10; i++)
      drive(1'b0, '0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
